// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions for the self-test master: response codes,
// sequencer states and response classification.
package axi_lite_pkg;

    localparam int unsigned IDX_W = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD,
        RD_DATA,
        DONE
    } state_t;

    // Anything other than OKAY/EXOKAY counts as a failed transfer.
    function automatic logic resp_is_error(input logic [1:0] resp);
        return (resp != RESP_OKAY) && (resp != RESP_EXOKAY);
    endfunction

endpackage

// File: rtl/axi_lite_selftest_pattern.sv
// Maps a word index to its target address and generated data word.
module axi_lite_selftest_pattern
    import axi_lite_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter logic [31:0] SEED      = 32'hA5A5_0000
) (
    input  logic [IDX_W-1:0]  idx,
    output logic [ADDR_W-1:0] addr_c,
    output logic [DATA_W-1:0] data_c
);

    // Both sums wrap modulo 2^width.
    assign addr_c = ADDR_W'(BASE_ADDR) + ADDR_W'({idx, 2'b00});
    assign data_c = DATA_W'(SEED) + DATA_W'(idx);

endmodule

// File: rtl/axi_lite_selftest_master.sv
// AXI4-Lite initiator that writes a word pattern to a slave, reads it back
// and flags any response or data mismatch; one transaction in flight at a time.
module axi_lite_selftest_master
    import axi_lite_pkg::*;
#(
    parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
    parameter int unsigned C_M_AXI_ADDR_WIDTH         = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH         = 32,
    parameter int unsigned C_M_TRANSACTIONS_NUM       = 4,
    parameter logic [31:0] C_DATA_SEED                = 32'hA5A5_0000,
    parameter int unsigned C_TIMEOUT_CYCLES           = 1024
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic                              INIT_AXI_TXN,
    output logic                              TXN_DONE,
    output logic                              ERROR,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int unsigned AW   = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW   = C_M_AXI_DATA_WIDTH;
    localparam int unsigned WD_W = 32;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_M_TRANSACTIONS_NUM - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(C_TIMEOUT_CYCLES - 1);
    localparam bit               WD_EN    = (C_TIMEOUT_CYCLES != 0);

    state_t state, next_state;

    logic             init_q;
    logic [IDX_W-1:0] idx, idx_d;
    logic             awvalid_q, awvalid_d;
    logic             wvalid_q, wvalid_d;
    logic             aw_done_q, aw_done_d;
    logic             w_done_q, w_done_d;
    logic             bready_q, bready_d;
    logic             arvalid_q, arvalid_d;
    logic             rready_q, rready_d;
    logic             txn_done_q, txn_done_d;
    logic             error_q, error_d;
    logic [AW-1:0]    addr_q, pat_addr;
    logic [DW-1:0]    data_q, pat_data;
    logic [WD_W-1:0]  wd_cnt, wd_cnt_d;

    logic init_pulse, last, active, timeout;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign init_pulse = INIT_AXI_TXN & ~init_q;
    assign last       = (idx == LAST_IDX);
    assign active     = (state == WR) || (state == WR_RESP) ||
                        (state == RD) || (state == RD_DATA);
    assign timeout    = WD_EN && active && (wd_cnt == WD_LIMIT);

    assign aw_hs = awvalid_q & M_AXI_AWREADY;
    assign w_hs  = wvalid_q  & M_AXI_WREADY;
    assign b_hs  = bready_q  & M_AXI_BVALID;
    assign ar_hs = arvalid_q & M_AXI_ARREADY;
    assign r_hs  = rready_q  & M_AXI_RVALID;

    // Address/data follow the next index so they are already valid when VALID rises.
    axi_lite_selftest_pattern #(
        .BASE_ADDR (C_M_TARGET_SLAVE_BASE_ADDR),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .SEED      (C_DATA_SEED)
    ) u_pattern (
        .idx    (idx_d),
        .addr_c (pat_addr),
        .data_c (pat_data)
    );

    // State and registered-output storage.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state      <= IDLE;
            init_q     <= INIT_AXI_TXN;
            idx        <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            txn_done_q <= 1'b0;
            error_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            wd_cnt     <= '0;
        end else begin
            state      <= next_state;
            init_q     <= INIT_AXI_TXN;
            idx        <= idx_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            bready_q   <= bready_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            txn_done_q <= txn_done_d;
            error_q    <= error_d;
            addr_q     <= pat_addr;
            data_q     <= pat_data;
            wd_cnt     <= wd_cnt_d;
        end
    end

    // Sequencer transitions; the watchdog overrides everything.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: if (init_pulse) next_state = WR;
            WR:         if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) next_state = WR_RESP;
            WR_RESP:    if (b_hs) next_state = last ? RD : WR;
            RD:         if (ar_hs) next_state = RD_DATA;
            RD_DATA:    if (r_hs) next_state = last ? DONE : RD;
            default:    next_state = IDLE;
        endcase
        if (timeout) next_state = DONE;
    end

    // Next values of the channel controls, index, status and watchdog.
    always_comb begin
        idx_d      = idx;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        txn_done_d = txn_done_q;
        error_d    = error_q;
        wd_cnt_d   = (active && (next_state == state)) ? wd_cnt + 1'b1 : '0;

        case (state)
            IDLE, DONE: begin
                if (init_pulse) begin
                    txn_done_d = 1'b0;
                    error_d    = 1'b0;
                    idx_d      = '0;
                    awvalid_d  = 1'b1;
                    wvalid_d   = 1'b1;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                end
            end
            WR: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (next_state == WR_RESP) bready_d = 1'b1;
            end
            WR_RESP: begin
                if (b_hs) begin
                    bready_d = 1'b0;
                    if (resp_is_error(M_AXI_BRESP)) error_d = 1'b1;
                    if (last) begin
                        idx_d     = '0;
                        arvalid_d = 1'b1;
                    end else begin
                        idx_d     = idx + 1'b1;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end
                end
            end
            RD: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            RD_DATA: begin
                if (r_hs) begin
                    rready_d = 1'b0;
                    if (resp_is_error(M_AXI_RRESP) || (M_AXI_RDATA != data_q)) error_d = 1'b1;
                    if (last) begin
                        txn_done_d = 1'b1;
                    end else begin
                        idx_d     = idx + 1'b1;
                        arvalid_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (timeout) begin
            awvalid_d  = 1'b0;
            wvalid_d   = 1'b0;
            bready_d   = 1'b0;
            arvalid_d  = 1'b0;
            rready_d   = 1'b0;
            error_d    = 1'b1;
            txn_done_d = 1'b1;
        end
    end

    assign TXN_DONE      = txn_done_q;
    assign ERROR         = error_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = data_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_selftest_master.sv
// Directed bench for axi_lite_selftest_master: memory-backed slave with
// per-word ready delays and fault injection, plus a timeout instance.
module tb_axi_lite_selftest_master;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        areset, init;
    logic        txn_done, error;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    logic        init_t, txn_done_t, error_t;
    logic [31:0] awaddr_t, wdata_t, araddr_t, rdata_t;
    logic [2:0]  awprot_t, arprot_t;
    logic [3:0]  wstrb_t;
    logic        awvalid_t, awready_t, wvalid_t, wready_t, bvalid_t, bready_t;
    logic        arvalid_t, arready_t, rvalid_t, rready_t;
    logic [1:0]  bresp_t, rresp_t;

    axi_lite_selftest_master dut (
        .ACLK(clk), .ARESET(areset), .INIT_AXI_TXN(init),
        .TXN_DONE(txn_done), .ERROR(error),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    axi_lite_selftest_master #(.C_TIMEOUT_CYCLES(16)) dut_t (
        .ACLK(clk), .ARESET(areset), .INIT_AXI_TXN(init_t),
        .TXN_DONE(txn_done_t), .ERROR(error_t),
        .M_AXI_AWADDR(awaddr_t), .M_AXI_AWPROT(awprot_t), .M_AXI_AWVALID(awvalid_t), .M_AXI_AWREADY(awready_t),
        .M_AXI_WDATA(wdata_t), .M_AXI_WSTRB(wstrb_t), .M_AXI_WVALID(wvalid_t), .M_AXI_WREADY(wready_t),
        .M_AXI_BRESP(bresp_t), .M_AXI_BVALID(bvalid_t), .M_AXI_BREADY(bready_t),
        .M_AXI_ARADDR(araddr_t), .M_AXI_ARPROT(arprot_t), .M_AXI_ARVALID(arvalid_t), .M_AXI_ARREADY(arready_t),
        .M_AXI_RDATA(rdata_t), .M_AXI_RRESP(rresp_t), .M_AXI_RVALID(rvalid_t), .M_AXI_RREADY(rready_t)
    );

    int          n_tests, n_fail;
    int          cfg_aw_delay[4], cfg_w_delay[4];
    int          cfg_bresp_word, cfg_corrupt_word;
    logic [31:0] mem[16];
    logic [31:0] wlog_addr[128], wlog_data[128];
    int          wr_total, rd_total, aw_rise, w_rise, stab_err;

    // Slave: acts at the falling edge on values the DUT will present at the next rising edge.
    initial begin
        bit          aw_fire, w_fire, b_fire, ar_fire, r_fire, aw_got, w_got, prev_aw, prev_w;
        logic [31:0] aw_cap, w_cap, ar_cap, prev_awaddr, prev_wdata;
        int          aw_wait, w_wait;
        aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
        aw_got = 0; w_got = 0; prev_aw = 0; prev_w = 0;
        aw_cap = '0; w_cap = '0; ar_cap = '0; prev_awaddr = '0; prev_wdata = '0;
        aw_wait = 0; w_wait = 0;
        wr_total = 0; rd_total = 0; aw_rise = 0; w_rise = 0; stab_err = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
        arready = 0; rvalid = 0; rresp = 2'b00; rdata = '0;
        forever begin
            @(negedge clk);
            if (areset) begin
                aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
                aw_got = 0; w_got = 0; prev_aw = 0; prev_w = 0;
                aw_wait = 0; w_wait = 0;
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            end else begin
                if (r_fire) rvalid = 0;
                if (b_fire) bvalid = 0;
                if (aw_fire) begin aw_got = 1; aw_wait = 0; end
                if (w_fire) begin w_got = 1; w_wait = 0; end
                if (ar_fire) begin
                    rvalid = 1;
                    rresp  = 2'b00;
                    rdata  = (int'(ar_cap[3:2]) == cfg_corrupt_word) ? 32'hDEAD_BEEF : mem[ar_cap[5:2]];
                    rd_total++;
                end
                if (aw_got && w_got && !bvalid) begin
                    mem[aw_cap[5:2]]    = w_cap;
                    wlog_addr[wr_total] = aw_cap;
                    wlog_data[wr_total] = w_cap;
                    wr_total++;
                    bresp  = (int'(aw_cap[3:2]) == cfg_bresp_word) ? 2'b10 : 2'b00;
                    bvalid = 1;
                    aw_got = 0;
                    w_got  = 0;
                end
                if (awvalid && !prev_aw) aw_rise++;
                if (wvalid && !prev_w) w_rise++;
                if (awvalid && prev_aw && awaddr != prev_awaddr) stab_err++;
                if (wvalid && prev_w && wdata != prev_wdata) stab_err++;
                prev_aw = awvalid; prev_awaddr = awaddr;
                prev_w  = wvalid;  prev_wdata  = wdata;
                awready = awvalid && (aw_wait >= cfg_aw_delay[awaddr[3:2]]);
                if (awvalid && !awready) aw_wait++;
                wready = wvalid && (w_wait >= cfg_w_delay[awaddr[3:2]]);
                if (wvalid && !wready) w_wait++;
                arready = arvalid;
                aw_fire = awvalid && awready;
                if (aw_fire) aw_cap = awaddr;
                w_fire = wvalid && wready;
                if (w_fire) w_cap = wdata;
                b_fire  = bvalid && bready;
                ar_fire = arvalid && arready;
                if (ar_fire) ar_cap = araddr;
                r_fire  = rvalid && rready;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_run();
        init = 1'b0;
        tick();
        init = 1'b1;
        tick();
        init = 1'b0;
        check("start_clears_done", 32'(txn_done), 32'd0);
        check("start_clears_error", 32'(error), 32'd0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (txn_done !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check(tag, 32'(txn_done), 32'd1);
    endtask

    task automatic check_writes(input string tag, input int base);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_awaddr"}, wlog_addr[base + i], 32'h4000_0000 + 32'(4 * i));
            check({tag, "_wdata"}, wlog_data[base + i], 32'hA5A5_0000 + 32'(i));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_done"}, 32'(txn_done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_valids"}, {29'd0, awvalid, wvalid, arvalid}, 32'd0);
        check({tag, "_readys"}, {30'd0, bready, rready}, 32'd0);
    endtask

    initial begin
        int w0, r0, a0, v0, s0, n;
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 4; i++) begin cfg_aw_delay[i] = 0; cfg_w_delay[i] = 0; end
        cfg_bresp_word = -1;
        cfg_corrupt_word = -1;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        init_t = 0; awready_t = 0; wready_t = 1; bresp_t = 2'b00; bvalid_t = 0;
        arready_t = 0; rdata_t = '0; rresp_t = 2'b00; rvalid_t = 0;

        // INIT already high during reset must not start a run afterwards.
        areset = 1'b1;
        init   = 1'b1;
        repeat (3) tick();
        check_idle_outputs("reset");
        areset = 1'b0;
        repeat (4) tick();
        check("no_spurious_start", 32'(awvalid), 32'd0);
        check("no_spurious_done", 32'(txn_done), 32'd0);

        // Ideal slave
        w0 = wr_total; r0 = rd_total; a0 = aw_rise; v0 = w_rise; s0 = stab_err;
        start_run();
        wait_done("ideal_done");
        check("ideal_error", 32'(error), 32'd0);
        check("ideal_wr_count", 32'(wr_total - w0), 32'd4);
        check("ideal_rd_count", 32'(rd_total - r0), 32'd4);
        check_writes("ideal", w0);

        // Alternating AW/W ready delays
        cfg_aw_delay = '{3, 0, 3, 0};
        cfg_w_delay  = '{0, 3, 0, 3};
        w0 = wr_total; r0 = rd_total; a0 = aw_rise; v0 = w_rise; s0 = stab_err;
        start_run();
        wait_done("delay_done");
        check("delay_error", 32'(error), 32'd0);
        check("delay_aw_pulses", 32'(aw_rise - a0), 32'd4);
        check("delay_w_pulses", 32'(w_rise - v0), 32'd4);
        check("delay_stability", 32'(stab_err - s0), 32'd0);
        check_writes("delay", w0);
        for (int i = 0; i < 4; i++) begin cfg_aw_delay[i] = 0; cfg_w_delay[i] = 0; end

        // Corrupted readback of word 2
        cfg_corrupt_word = 2;
        r0 = rd_total;
        start_run();
        wait_done("corrupt_done");
        check("corrupt_error", 32'(error), 32'd1);
        check("corrupt_rd_count", 32'(rd_total - r0), 32'd4);
        cfg_corrupt_word = -1;

        // SLVERR on word 1; the accepted start must have cleared the previous ERROR
        cfg_bresp_word = 1;
        w0 = wr_total; r0 = rd_total;
        start_run();
        wait_done("slverr_done");
        check("slverr_error", 32'(error), 32'd1);
        check("slverr_wr_count", 32'(wr_total - w0), 32'd4);
        check("slverr_rd_count", 32'(rd_total - r0), 32'd4);
        cfg_bresp_word = -1;

        // Watchdog: AWREADY stuck low on the 16-cycle instance
        init_t = 1'b1;
        n = 0;
        while (awvalid_t !== 1'b1 && n < 10) begin tick(); n++; end
        check("to_awvalid_rise", 32'(awvalid_t), 32'd1);
        n = 0;
        while (txn_done_t !== 1'b1 && n < 100) begin tick(); n++; end
        check("to_latency", 32'(n), 32'd16);
        check("to_error", 32'(error_t), 32'd1);
        check("to_valids", {29'd0, awvalid_t, wvalid_t, arvalid_t}, 32'd0);
        check("to_readys", {30'd0, bready_t, rready_t}, 32'd0);
        init_t = 1'b0;

        // Reset while waiting in RD_DATA aborts the run and clears ERROR
        cfg_bresp_word = 0;
        start_run();
        n = 0;
        while (rready !== 1'b1 && n < 300) begin tick(); n++; end
        check("abort_in_rd_data", 32'(rready), 32'd1);
        check("abort_error_before", 32'(error), 32'd1);
        areset = 1'b1;
        repeat (2) tick();
        areset = 1'b0;
        check_idle_outputs("abort_reset");
        cfg_bresp_word = -1;
        repeat (4) tick();
        check("abort_no_restart", 32'(awvalid), 32'd0);

        // Clean run after the abort
        w0 = wr_total;
        start_run();
        wait_done("rerun_done");
        check("rerun_error", 32'(error), 32'd0);
        check_writes("rerun", w0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
